gmac_tx_arbiter: RTL

//  Shares the single GMAC transmit channel (ValIn0/SoFIn0/EoFIn0/ReqIn0/DataIn0,

---
 rtl/gmac_tx_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gmac_tx_arbiter.sv
// gmac_tx_arbiter: round-robin sharing of the single GMAC transmit channel
// between N_REQ byte-stream requesters. Each frame runs through
// request -> GMAC confirm -> grant/stream -> inter-frame gap.
//
// Handshake: a requester raises req_i[k] and holds it until grant_o[k] rises.
// While grant_o[k] is high the requester may present bytes with val_i[k];
// every byte with val_i[k]=1 is taken in the cycle it is presented (there is
// no back-pressure), and appears on gmac_* exactly one cycle later. grant_o[k]
// falls the cycle after the eof byte (or the MAX_LEN-th byte) was taken.
module gmac_tx_arbiter #(
  parameter int N_REQ    = 2,
  parameter int CONF_TMO = 1023,
  parameter int MAX_LEN  = 1500,
  parameter int GAP_CYC  = 12
) (
  input  logic               clk125,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   val_i,
  input  logic [N_REQ-1:0]   sof_i,
  input  logic [N_REQ-1:0]   eof_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               gmac_req,
  input  logic               gmac_req_confirm,
  output logic               gmac_val,
  output logic               gmac_sof,
  output logic               gmac_eof,
  output logic [7:0]         gmac_data,
  output logic               busy,
  output logic [15:0]        tmo_cnt,
  output logic [15:0]        trunc_cnt,
  output logic [1:0]         o_dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] LP_TMO_LAST = 16'(CONF_TMO - 1);
  localparam logic [15:0] LP_LEN_LAST = 16'(MAX_LEN - 1);
  localparam logic [15:0] LP_GAP_LAST = 16'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_XFER = 2'd2, S_GAP = 2'd3} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_rr;
  logic [IW-1:0]    r_win;
  logic [15:0]      r_cnt;
  logic [15:0]      r_bytes;
  logic             r_in_frame;
  logic [N_REQ-1:0] r_grant;
  logic             r_gmac_req;
  logic             r_val;
  logic             r_sof;
  logic             r_eof;
  logic [7:0]       r_data;
  logic [15:0]      r_tmo;
  logic [15:0]      r_trunc;

  logic [IW-1:0]    w_next_win;
  logic [IW-1:0]    w_rr_next;
  logic [N_REQ-1:0] w_win_oh;
  logic             w_val;
  logic             w_sof;
  logic             w_eof;
  logic [7:0]       w_data;
  logic             w_accept;
  logic             w_len_last;

  // Winner search: first requesting index at or after the rr pointer, wrapping.
  // Walking offsets from high to low lets the smallest offset win.
  always_comb begin
    w_next_win = r_rr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(r_rr) + i) % N_REQ]) w_next_win = IW'((int'(r_rr) + i) % N_REQ);
    end
  end

  assign w_rr_next  = (int'(r_win) == N_REQ - 1) ? '0 : r_win + IW'(1);
  assign w_win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
  assign w_val      = val_i[r_win];
  assign w_sof      = sof_i[r_win];
  assign w_eof      = eof_i[r_win];
  assign w_data     = data_i[{r_win, 3'b000} +: 8];
  // Bytes ahead of the first sof are not part of a frame and are dropped.
  assign w_accept   = (r_state == S_XFER) && w_val && (r_in_frame || w_sof);
  assign w_len_last = (r_bytes == LP_LEN_LAST);

  // Frame sequencer with registered GMAC-side and requester-side outputs.
  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_bytes    <= '0;
      r_in_frame <= 1'b0;
      r_grant    <= '0;
      r_gmac_req <= 1'b0;
      r_val      <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_data     <= '0;
      r_tmo      <= '0;
      r_trunc    <= '0;
    end else begin
      r_val  <= 1'b0;
      r_sof  <= 1'b0;
      r_eof  <= 1'b0;
      r_data <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req_i) begin
            r_win      <= w_next_win;
            r_gmac_req <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (gmac_req_confirm) begin
            r_gmac_req <= 1'b0;
            r_grant    <= w_win_oh;
            r_bytes    <= '0;
            r_in_frame <= 1'b0;
            r_state    <= S_XFER;
          end else if (!req_i[r_win]) begin
            r_gmac_req <= 1'b0;
            r_state    <= S_IDLE;
          end else if (r_cnt == LP_TMO_LAST) begin
            r_gmac_req <= 1'b0;
            r_cnt      <= '0;
            if (r_tmo != 16'hFFFF) r_tmo <= r_tmo + 16'd1;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_XFER: begin
          if (w_accept) begin
            r_val      <= 1'b1;
            r_data     <= w_data;
            r_sof      <= w_sof && !r_in_frame;
            r_in_frame <= 1'b1;
            r_bytes    <= r_bytes + 16'd1;
            if (w_eof || w_len_last) begin
              r_eof   <= 1'b1;
              r_grant <= '0;
              r_cnt   <= '0;
              r_state <= S_GAP;
              if (!w_eof && r_trunc != 16'hFFFF) r_trunc <= r_trunc + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == LP_GAP_LAST) begin
            r_rr    <= w_rr_next;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_o     = r_grant;
  assign gmac_req    = r_gmac_req;
  assign gmac_val    = r_val;
  assign gmac_sof    = r_sof;
  assign gmac_eof    = r_eof;
  assign gmac_data   = r_data;
  assign busy        = (r_state != S_IDLE);
  assign tmo_cnt     = r_tmo;
  assign trunc_cnt   = r_trunc;
  assign o_dbg_state = r_state;

endmodule
